// File: rtl/uart_cal_pkg.sv
// Shared constants, encodings and character classes for the UART calculator
// command parser.
package uart_cal_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_C_UP  = 8'h43;
    localparam logic [7:0] CH_C_LO  = 8'h63;
    localparam logic [7:0] CH_ESC   = 8'h1B;

    typedef enum logic {
        S_A,
        S_B
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_CHAR = 2'd1,
        ERR_SYNTAX   = 2'd2,
        ERR_TOO_LONG = 2'd3
    } err_t;

    typedef enum logic [2:0] {
        CC_DIGIT = 3'd0,
        CC_OP    = 3'd1,
        CC_TERM  = 3'd2,
        CC_SPACE = 3'd3,
        CC_CLEAR = 3'd4,
        CC_BAD   = 3'd5
    } char_class_t;

    // Only meaningful for bytes already classified as CC_OP.
    function automatic op_t op_decode(input logic [7:0] b);
        case (b)
            CH_PLUS:  return OP_ADD;
            CH_MINUS: return OP_SUB;
            default:  return OP_MUL;
        endcase
    endfunction

endpackage

// File: rtl/uart_cal_parser_char_class.sv
// Combinational byte classifier: maps an ASCII byte to its parser character
// class and, for decimal digits, the 4-bit digit value.
module cal_char_class
    import uart_cal_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic [2:0] cls,
    output logic [3:0] digit
);

    always_comb begin
        cls   = CC_BAD;
        // Low nibble equals byte - 0x30 across the whole '0'..'9' range.
        digit = byte_in[3:0];
        if (byte_in >= CH_0 && byte_in <= CH_9) begin
            cls = CC_DIGIT;
        end else begin
            case (byte_in)
                CH_PLUS, CH_MINUS, CH_STAR: cls = CC_OP;
                CH_EQ, CH_CR:               cls = CC_TERM;
                CH_SPACE:                   cls = CC_SPACE;
                CH_C_UP, CH_C_LO, CH_ESC:   cls = CC_CLEAR;
                default:                    cls = CC_BAD;
            endcase
        end
    end

endmodule

// File: rtl/uart_cal_parser.sv
// Parses "<A><op><B><term>" from the UART RX byte stream and emits a one-cycle
// result pulse, or an error pulse with a held error code.
module uart_cal_parser
    import uart_cal_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int OP_W       = 14,
    parameter int RES_W      = 28
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic signed [RES_W-1:0] result,
    output logic                    res_valid,
    output logic                    err,
    output logic [1:0]              err_code
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

    state_t                  state, state_nx;
    op_t                     op_q, op_nx;
    logic [OP_W-1:0]         acc_a, acc_a_nx;
    logic [OP_W-1:0]         acc_b, acc_b_nx;
    logic [CNT_W-1:0]        cnt_a, cnt_a_nx;
    logic [CNT_W-1:0]        cnt_b, cnt_b_nx;
    logic signed [RES_W-1:0] result_nx;
    logic                    res_valid_nx;
    logic                    err_nx;
    logic [1:0]              err_code_nx;
    logic                    rx_valid_d;
    logic                    accept;
    logic                    clr;
    logic [2:0]              cls;
    logic [3:0]              digit;
    logic [OP_W-1:0]         acc_sel;
    logic [OP_W-1:0]         acc_shift;

    function automatic logic signed [RES_W-1:0] alu(
        input op_t             o,
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b
    );
        logic signed [RES_W-1:0] ax;
        logic signed [RES_W-1:0] bx;
        ax = $signed({{(RES_W-OP_W){1'b0}}, a});
        bx = $signed({{(RES_W-OP_W){1'b0}}, b});
        case (o)
            OP_ADD:  return ax + bx;
            OP_SUB:  return ax - bx;
            default: return ax * bx;
        endcase
    endfunction

    // One byte per rx_valid rising edge, however long valid is held.
    assign accept = rx_valid & ~rx_valid_d;

    cal_char_class u_char_class (
        .byte_in (rx_data),
        .cls     (cls),
        .digit   (digit)
    );

    assign acc_sel   = (state == S_A) ? acc_a : acc_b;
    assign acc_shift = (acc_sel << 3) + (acc_sel << 1) + {{(OP_W-4){1'b0}}, digit};

    always_comb begin
        state_nx     = state;
        op_nx        = op_q;
        acc_a_nx     = acc_a;
        acc_b_nx     = acc_b;
        cnt_a_nx     = cnt_a;
        cnt_b_nx     = cnt_b;
        result_nx    = result;
        res_valid_nx = 1'b0;
        err_nx       = 1'b0;
        err_code_nx  = err_code;
        clr          = 1'b0;

        if (accept) begin
            case (cls)
                CC_SPACE: ;
                CC_CLEAR: clr = 1'b1;
                CC_DIGIT: begin
                    if (state == S_A) begin
                        if (cnt_a == CNT_MAX) begin
                            err_nx      = 1'b1;
                            err_code_nx = ERR_TOO_LONG;
                            clr         = 1'b1;
                        end else begin
                            acc_a_nx = acc_shift;
                            cnt_a_nx = cnt_a + 1'b1;
                        end
                    end else begin
                        if (cnt_b == CNT_MAX) begin
                            err_nx      = 1'b1;
                            err_code_nx = ERR_TOO_LONG;
                            clr         = 1'b1;
                        end else begin
                            acc_b_nx = acc_shift;
                            cnt_b_nx = cnt_b + 1'b1;
                        end
                    end
                end
                CC_OP: begin
                    if (state == S_A && cnt_a != '0) begin
                        op_nx    = op_decode(rx_data);
                        state_nx = S_B;
                    end else begin
                        err_nx      = 1'b1;
                        err_code_nx = ERR_SYNTAX;
                        clr         = 1'b1;
                    end
                end
                CC_TERM: begin
                    if (state == S_B && cnt_b != '0) begin
                        result_nx    = alu(op_q, acc_a, acc_b);
                        res_valid_nx = 1'b1;
                    end else begin
                        err_nx      = 1'b1;
                        err_code_nx = ERR_SYNTAX;
                    end
                    clr = 1'b1;
                end
                default: begin
                    err_nx      = 1'b1;
                    err_code_nx = ERR_BAD_CHAR;
                    clr         = 1'b1;
                end
            endcase
        end

        // Every expression-ending event returns to an empty S_A.
        if (clr) begin
            state_nx = S_A;
            op_nx    = OP_ADD;
            acc_a_nx = '0;
            acc_b_nx = '0;
            cnt_a_nx = '0;
            cnt_b_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= S_A;
            op_q       <= OP_ADD;
            acc_a      <= '0;
            acc_b      <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            result     <= '0;
            res_valid  <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            // Held high so a valid already asserted at release is not taken.
            rx_valid_d <= 1'b1;
        end else begin
            state      <= state_nx;
            op_q       <= op_nx;
            acc_a      <= acc_a_nx;
            acc_b      <= acc_b_nx;
            cnt_a      <= cnt_a_nx;
            cnt_b      <= cnt_b_nx;
            result     <= result_nx;
            res_valid  <= res_valid_nx;
            err        <= err_nx;
            err_code   <= err_code_nx;
            rx_valid_d <= rx_valid;
        end
    end

endmodule

// File: tb/tb_uart_cal_parser.sv
// Directed bench for uart_cal_parser: expressions, errors, clear, reset and
// fast back-to-back bytes against hand-computed values.
module tb_uart_cal_parser;

    logic               clk;
    logic               n_rst;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic signed [27:0] result;
    logic               res_valid;
    logic               err;
    logic [1:0]         err_code;

    int tests;
    int fails;
    int rv_cnt;
    int er_cnt;
    int both_cnt;
    logic pulse_rv;
    logic pulse_er;

    uart_cal_parser dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .result    (result),
        .res_valid (res_valid),
        .err       (err),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rv_cnt   = 0;
        er_cnt   = 0;
        both_cnt = 0;
    end

    always @(negedge clk) begin
        if (res_valid === 1'b1) rv_cnt = rv_cnt + 1;
        if (err === 1'b1) er_cnt = er_cnt + 1;
        if (res_valid === 1'b1 && err === 1'b1) both_cnt = both_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        pulse_rv = res_valid;
        pulse_er = err;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_fast(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_data  = s[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (result !== 28'd0) begin fails++; $display("FAIL reset_result got %0d want 0", result); end
        tests++;
        if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        tests++;
        if (err_code !== 2'd0) begin fails++; $display("FAIL reset_err_code got %0d want 0", err_code); end
    endtask

    task automatic test_add();
        int rv0, er0;
        rv0 = rv_cnt; er0 = er_cnt;
        send_str("12+34=");
        tests++;
        if (pulse_rv !== 1'b1) begin fails++; $display("FAIL add_latency got %b want 1", pulse_rv); end
        tests++;
        if (result !== 28'd46) begin fails++; $display("FAIL add_result got %0d want 46", result); end
        tests++;
        if (rv_cnt - rv0 != 1) begin fails++; $display("FAIL add_rv_cycles got %0d want 1", rv_cnt - rv0); end
        tests++;
        if (er_cnt - er0 != 0) begin fails++; $display("FAIL add_err_cycles got %0d want 0", er_cnt - er0); end
    endtask

    task automatic test_sub_cr();
        int rv0;
        rv0 = rv_cnt;
        send_str("5-9");
        send_byte(8'h0D);
        tests++;
        if (result !== 28'hFFFFFFC) begin fails++; $display("FAIL sub_result got %h want FFFFFFC", result); end
        tests++;
        if (rv_cnt - rv0 != 1) begin fails++; $display("FAIL sub_rv_cycles got %0d want 1", rv_cnt - rv0); end
    endtask

    task automatic test_mul_max();
        send_str("9999*9999=");
        tests++;
        if (result !== 28'd99980001) begin fails++; $display("FAIL mul_result got %0d want 99980001", result); end
        tests++;
        if (pulse_rv !== 1'b1) begin fails++; $display("FAIL mul_pulse got %b want 1", pulse_rv); end
    endtask

    task automatic test_spaces();
        int er0;
        er0 = er_cnt;
        send_str("7 * 8 =");
        tests++;
        if (result !== 28'd56) begin fails++; $display("FAIL space_result got %0d want 56", result); end
        tests++;
        if (er_cnt - er0 != 0) begin fails++; $display("FAIL space_err_cycles got %0d want 0", er_cnt - er0); end
    endtask

    task automatic test_too_long();
        int er0, rv0;
        er0 = er_cnt; rv0 = rv_cnt;
        send_str("1234");
        tests++;
        if (er_cnt - er0 != 0) begin fails++; $display("FAIL long_early_err got %0d want 0", er_cnt - er0); end
        send_byte("5");
        tests++;
        if (pulse_er !== 1'b1) begin fails++; $display("FAIL long_pulse got %b want 1", pulse_er); end
        tests++;
        if (err_code !== 2'd3) begin fails++; $display("FAIL long_code got %0d want 3", err_code); end
        tests++;
        if (er_cnt - er0 != 1) begin fails++; $display("FAIL long_err_cycles got %0d want 1", er_cnt - er0); end
        send_str("2+2=");
        tests++;
        if (result !== 28'd4) begin fails++; $display("FAIL long_follow_result got %0d want 4", result); end
        tests++;
        if (rv_cnt - rv0 != 1) begin fails++; $display("FAIL long_rv_cycles got %0d want 1", rv_cnt - rv0); end
    endtask

    task automatic test_syntax();
        int er0, rv0;
        er0 = er_cnt; rv0 = rv_cnt;
        // '+' with no A, then '=' while still collecting A: two errors.
        send_str("+3=");
        tests++;
        if (er_cnt - er0 != 2) begin fails++; $display("FAIL syn_err_cycles got %0d want 2", er_cnt - er0); end
        tests++;
        if (err_code !== 2'd2) begin fails++; $display("FAIL syn_code got %0d want 2", err_code); end
        er0 = er_cnt;
        send_str("1+=");
        tests++;
        if (pulse_er !== 1'b1) begin fails++; $display("FAIL syn_empty_b got %b want 1", pulse_er); end
        send_str("1+2+");
        tests++;
        if (pulse_er !== 1'b1) begin fails++; $display("FAIL syn_second_op got %b want 1", pulse_er); end
        tests++;
        if (rv_cnt - rv0 != 0) begin fails++; $display("FAIL syn_rv_cycles got %0d want 0", rv_cnt - rv0); end
    endtask

    task automatic test_bad_char();
        int er0;
        er0 = er_cnt;
        send_str("4x");
        tests++;
        if (er_cnt - er0 != 1) begin fails++; $display("FAIL bad_err_cycles got %0d want 1", er_cnt - er0); end
        tests++;
        if (err_code !== 2'd1) begin fails++; $display("FAIL bad_code got %0d want 1", err_code); end
    endtask

    task automatic test_clear();
        int er0, rv0;
        er0 = er_cnt; rv0 = rv_cnt;
        send_str("12+C");
        send_str("1+1=");
        tests++;
        if (result !== 28'd2) begin fails++; $display("FAIL clr_result got %0d want 2", result); end
        tests++;
        if (er_cnt - er0 != 0) begin fails++; $display("FAIL clr_err_cycles got %0d want 0", er_cnt - er0); end
        tests++;
        if (rv_cnt - rv0 != 1) begin fails++; $display("FAIL clr_rv_cycles got %0d want 1", rv_cnt - rv0); end
        tests++;
        if (err_code !== 2'd1) begin fails++; $display("FAIL clr_code_held got %0d want 1", err_code); end
    endtask

    task automatic test_reset_mid();
        int er0, rv0;
        send_str("9*");
        er0 = er_cnt; rv0 = rv_cnt;
        @(negedge clk);
        rx_data  = "5";
        rx_valid = 1'b1;
        n_rst    = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (rv_cnt - rv0 != 0 || er_cnt - er0 != 0) begin
            fails++; $display("FAIL rstmid_pulses got rv=%0d err=%0d want 0/0", rv_cnt - rv0, er_cnt - er0);
        end
        tests++;
        if (result !== 28'd0) begin fails++; $display("FAIL rstmid_result got %0d want 0", result); end
        tests++;
        if (err_code !== 2'd0) begin fails++; $display("FAIL rstmid_code got %0d want 0", err_code); end
        send_str("3+3=");
        tests++;
        if (result !== 28'd6) begin fails++; $display("FAIL rstmid_follow got %0d want 6", result); end
    endtask

    task automatic test_back_to_back();
        int rv0;
        rv0 = rv_cnt;
        send_fast("8-3=");
        tests++;
        if (result !== 28'd5) begin fails++; $display("FAIL b2b_result got %0d want 5", result); end
        tests++;
        if (rv_cnt - rv0 != 1) begin fails++; $display("FAIL b2b_rv_cycles got %0d want 1", rv_cnt - rv0); end
        rv0 = rv_cnt;
        send_fast("25*40=");
        tests++;
        if (result !== 28'd1000) begin fails++; $display("FAIL b2b_mul got %0d want 1000", result); end
        tests++;
        if (rv_cnt - rv0 != 1) begin fails++; $display("FAIL b2b_mul_cycles got %0d want 1", rv_cnt - rv0); end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        pulse_rv = 1'b0;
        pulse_er = 1'b0;
        n_rst    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_add();
        test_sub_cr();
        test_mul_max();
        test_spaces();
        test_too_long();
        test_syntax();
        test_bad_char();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (both_cnt != 0) begin fails++; $display("FAIL exclusive_pulses got %0d want 0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
